// File: rtl/alu_pkg.sv
// Shared ALU opcodes, widths and the response entry layout.
// Used by the sequencer, its response FIFO and the bus interface.
package alu_pkg;

  localparam int OPERAND_W = 32;
  localparam int OPCODE_W  = 4;
  localparam int RESULT_W  = 33;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_SLL = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SRL = 4'b0101;

  typedef struct packed {
    logic                illegal;
    logic [RESULT_W-1:0] result;
  } rsp_entry_t;

  function automatic logic is_legal_op(
    input logic [OPCODE_W-1:0] op
  );
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SLL, OP_SRL: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU sequencer.
// master: sequencer side; slave: requester/ALU/consumer side.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [OPERAND_W-1:0] req_operand1;
  logic [OPERAND_W-1:0] req_operand2;
  logic [OPCODE_W-1:0]  req_opcode;

  logic [OPERAND_W-1:0] alu_operand1;
  logic [OPERAND_W-1:0] alu_operand2;
  logic [OPCODE_W-1:0]  alu_opcode;
  logic [RESULT_W-1:0]  alu_result;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [RESULT_W-1:0]  rsp_result;
  logic                 rsp_illegal;

  modport master (
    input  req_valid, req_operand1, req_operand2,
    input  req_opcode, alu_result, rsp_ready,
    output req_ready, alu_operand1, alu_operand2,
    output alu_opcode, rsp_valid, rsp_result,
    output rsp_illegal
  );

  modport slave (
    output req_valid, req_operand1, req_operand2,
    output req_opcode, alu_result, rsp_ready,
    input  req_ready, alu_operand1, alu_operand2,
    input  alu_opcode, rsp_valid, rsp_result,
    input  rsp_illegal
  );

endinterface

// File: rtl/alu_seq_rsp_fifo.sv
// In-order response FIFO; no fall-through, head reads 0 when empty.
// Ports: clock, reset, push/push_data, pop, head, valid.
module alu_seq_rsp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issues ops to a registered ALU, returns results in order with credits.
// Ports: clock, reset, bus (master). Option: ALU_SEQ_OPCODE_CHECK_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int RSP_DEPTH   = 4
) (
  input logic             clock,
  input logic             reset,
  alu_sequencer_if.master bus
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0]        outstanding;
  logic                 accept;
  logic                 pop;
  logic [ALU_LATENCY:0] vpipe;
  logic                 wr_ill;
  rsp_entry_t           wr_data;
  rsp_entry_t           head;
  logic                 head_valid;

  // Credits cover in-flight plus stored ops, so the FIFO never overflows.
  assign bus.req_ready = (outstanding < CW'(RSP_DEPTH));
  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.alu_operand1 <= '0;
      bus.alu_operand2 <= '0;
      bus.alu_opcode   <= '0;
    end else if (accept) begin
      bus.alu_operand1 <= bus.req_operand1;
      bus.alu_operand2 <= bus.req_operand2;
      bus.alu_opcode   <= bus.req_opcode;
    end
  end

  // Stage ALU_LATENCY marks the cycle the ALU output belongs to an op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= accept;
      for (int i = 1; i <= ALU_LATENCY; i++)
        vpipe[i] <= vpipe[i-1];
    end
  end

`ifdef ALU_SEQ_OPCODE_CHECK_EN
  logic [ALU_LATENCY:0] ipipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ipipe <= '0;
    end else begin
      ipipe[0] <= accept && !is_legal_op(bus.req_opcode);
      for (int i = 1; i <= ALU_LATENCY; i++)
        ipipe[i] <= ipipe[i-1];
    end
  end

  assign wr_ill = ipipe[ALU_LATENCY];
`else
  assign wr_ill = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign wr_data.illegal = wr_ill;
  assign wr_data.result  = bus.alu_result;

  alu_seq_rsp_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vpipe[ALU_LATENCY]),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .valid     (head_valid)
  );

  assign bus.rsp_valid   = head_valid;
  assign bus.rsp_result  = head.result;
  assign bus.rsp_illegal = head.illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a registered ALU.
// Honours ALU_SEQ_OPCODE_CHECK_EN for the expected illegal flag.
module tb_alu_sequencer;

  typedef struct {
    logic [32:0] res;
    logic        ill;
    int          e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t pend_e;
  logic pend_acc = 1'b0;
  logic pend_pop = 1'b0;
  logic ev;

  alu_sequencer_if bus();

  alu_sequencer #(
    .ALU_LATENCY (1),
    .RSP_DEPTH   (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_fn(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b
  );
    case (op)
      4'b0000: return {1'b0, a} + {1'b0, b};
      4'b1000: return {1'b0, a} - {1'b0, b};
      4'b0111: return {1'b0, a & b};
      4'b0110: return {1'b0, a | b};
      4'b0100: return {1'b0, a ^ b};
      4'b0001: return {1'b0, a} << b[4:0];
      4'b0101: return {1'b0, a >> b[4:0]};
      default: return 33'd0;
    endcase
  endfunction

  function automatic logic exp_ill(input logic [3:0] op);
`ifdef ALU_SEQ_OPCODE_CHECK_EN
    return !(op inside {4'b0000, 4'b1000, 4'b0111, 4'b0110,
                        4'b0100, 4'b0001, 4'b0101});
`else
    return 1'b0;
`endif
  endfunction

  // Registered ALU stand-in, no reset.
  always @(posedge clk)
    bus.alu_result <= alu_fn(bus.alu_opcode, bus.alu_operand1,
                             bus.alu_operand2);

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: accepted-not-popped ops, result due two edges after accept.
  always @(negedge clk) begin
    if (rst) q.delete();
    ev = (q.size() > 0) && (q[0].e0 + 2 <= cyc);
    check("req_ready", 64'(bus.req_ready), 64'(q.size() < 4));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    if (ev) begin
      check("rsp_result", 64'(bus.rsp_result), 64'(q[0].res));
      check("rsp_illegal", 64'(bus.rsp_illegal), 64'(q[0].ill));
    end
    pend_pop = !rst && ev && bus.rsp_ready;
    pend_acc = !rst && bus.req_valid && (q.size() < 4);
    pend_e.res = alu_fn(bus.req_opcode, bus.req_operand1,
                        bus.req_operand2);
    pend_e.ill = exp_ill(bus.req_opcode);
    pend_e.e0  = 0;
  end

  always @(posedge clk) begin
    cyc++;
    if (pend_pop) void'(q.pop_front());
    if (pend_acc) begin
      pend_e.e0 = cyc;
      q.push_back(pend_e);
    end
  end

  task automatic step(input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic rr);
    bus.req_valid    = v;
    bus.req_opcode   = op;
    bus.req_operand1 = a;
    bus.req_operand2 = b;
    bus.rsp_ready    = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic one(input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    step(1'b1, op, a, b, 1'b1);
    repeat (3) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
  endtask

  logic [3:0] legal_ops [7] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110,
                                4'b0100, 4'b0001, 4'b0101};

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_opcode   = 4'h0;
    bus.req_operand1 = 32'h0;
    bus.req_operand2 = 32'h0;
    bus.rsp_ready    = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    check("rst_alu_op1", 64'(bus.alu_operand1), 64'd0);
    check("rst_alu_op2", 64'(bus.alu_operand2), 64'd0);
    check("rst_alu_opc", 64'(bus.alu_opcode), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ADD 5,7: response visible after the second edge.
    step(1'b1, 4'b0000, 32'd5, 32'd7, 1'b1);
    check("add_alu_op1", 64'(bus.alu_operand1), 64'd5);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("add_early", 64'(bus.rsp_valid), 64'd0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("add_valid", 64'(bus.rsp_valid), 64'd1);
    check("add_result", 64'(bus.rsp_result), 64'd12);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

    one(4'b1000, 32'd3, 32'd5);
    one(4'b0001, 32'd1, 32'd4);
    one(4'b0101, 32'h8000_0000, 32'd31);
    one(4'b0011, 32'd9, 32'd9);

    // Credit exhaustion, then release.
    step(1'b1, 4'b0000, 32'd1, 32'd2, 1'b0);
    step(1'b1, 4'b1000, 32'd10, 32'd3, 1'b0);
    step(1'b1, 4'b0111, 32'hF0F0, 32'hFF00, 1'b0);
    step(1'b1, 4'b0110, 32'h0F, 32'hF0, 1'b0);
    repeat (4) step(1'b1, 4'b0100, 32'hAA, 32'h55, 1'b0);
    check("full_req_ready", 64'(bus.req_ready), 64'd0);
    step(1'b1, 4'b0100, 32'hAA, 32'h55, 1'b1);
    step(1'b1, 4'b0100, 32'hAA, 32'h55, 1'b1);
    repeat (8) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Refill, then streaming pop+accept at full credit use.
    repeat (6) step(1'b1, 4'b0000, $urandom, $urandom, 1'b0);
    repeat (10) step(1'b1, 4'b1000, $urandom, $urandom, 1'b1);
    repeat (8) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Reset with ops in flight and one stored.
    step(1'b1, 4'b0000, 32'd4, 32'd4, 1'b0);
    step(1'b1, 4'b0000, 32'd5, 32'd5, 1'b0);
    step(1'b1, 4'b0000, 32'd6, 32'd6, 1'b0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("async_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 4'b0000, 32'd1, 32'd1, 1'b0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    check("post_rst_result", 64'(bus.rsp_result), 64'd2);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] b;
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                       : legal_ops[$urandom_range(0, 6)];
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31))
                                       : $urandom;
      step($urandom_range(0, 9) < 7, op, $urandom, b,
           $urandom_range(0, 9) < 6);
    end
    repeat (10) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("drain_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
